// File: rtl/fmul_rs_sched_if.sv
// Bus bundle between the FP-multiply reservation station and the core:
// issue port, CDB snoop, fpMult operand/result lines and the result handshake.
interface fmul_rs_sched_if #(
  parameter int TAG_W   = 4,
  parameter int NUM_ENT = 3
);
  logic               issue_valid;
  logic               issue_ready;
  logic [TAG_W-1:0]   issue_tag;
  logic [TAG_W-1:0]   issue_qj;
  logic [TAG_W-1:0]   issue_qk;
  logic [31:0]        issue_vj;
  logic [31:0]        issue_vk;
  logic               cdb_valid;
  logic [TAG_W-1:0]   cdb_tag;
  logic [31:0]        cdb_data;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_res;
  logic               out_valid;
  logic [TAG_W-1:0]   out_tag;
  logic [31:0]        out_data;
  logic               out_ready;
  logic [NUM_ENT-1:0] busy;

  // core / fpMult side
  modport master (
    output issue_valid, issue_qj, issue_qk, issue_vj, issue_vk,
    output cdb_valid, cdb_tag, cdb_data, mul_res, out_ready,
    input  issue_ready, issue_tag, mul_a, mul_b, out_valid, out_tag, out_data, busy
  );

  // reservation station side
  modport slave (
    input  issue_valid, issue_qj, issue_qk, issue_vj, issue_vk,
    input  cdb_valid, cdb_tag, cdb_data, mul_res, out_ready,
    output issue_ready, issue_tag, mul_a, mul_b, out_valid, out_tag, out_data, busy
  );
endinterface

// File: rtl/fmul_rs_sched.sv
// Reservation-station scheduler for the shared single-precision fpMult unit.
// Optional macro FMUL_RS_FLUSH_EN adds a flush input that empties the station.
//   state    | meaning
//   S_IDLE   | multiplier free, dispatch lowest ready entry
//   S_EXEC   | operands on mul_a/mul_b, latency counter running
//   S_RESULT | product offered on out_*, waiting for out_ready
module fmul_rs_sched #(
  parameter int NUM_ENT  = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 4,
  parameter int LAT      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fmul_rs_sched_if.slave bus
`ifdef FMUL_RS_FLUSH_EN
  , input logic          flush
`endif
);

  localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
  localparam int CNT_W = $clog2(LAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESULT} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_ENT-1:0] r_busy, r_rdy_j, r_rdy_k;
  logic [TAG_W-1:0]   r_qj [NUM_ENT];
  logic [TAG_W-1:0]   r_qk [NUM_ENT];
  logic [31:0]        r_vj [NUM_ENT];
  logic [31:0]        r_vk [NUM_ENT];
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_sel;
  logic [31:0]        r_mul_a, r_mul_b, r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_valid;

  logic               w_flush;
  logic [IDX_W-1:0]   w_free_idx, w_disp_idx;
  logic               w_any_free, w_any_ready, w_issue_fire;
  logic [NUM_ENT-1:0] w_ready;
  logic               w_dispatch, w_finish, w_handoff;

`ifdef FMUL_RS_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Only IDLE dispatches, so no entry is executing whenever readiness is used.
  assign w_ready      = r_busy & r_rdy_j & r_rdy_k;
  assign w_any_free   = ~&r_busy;
  assign w_any_ready  = |w_ready;
  assign w_issue_fire = bus.issue_valid & w_any_free & ~w_flush;

  always_comb begin
    w_free_idx = '0;
    w_disp_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!r_busy[i])  w_free_idx = IDX_W'(i);
      if (w_ready[i])  w_disp_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_finish    = 1'b0;
    w_handoff   = 1'b0;
    if (w_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_ready) begin
            w_dispatch  = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            w_finish    = 1'b1;
            w_state_nxt = S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            w_handoff   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Entry storage: issue (with same-cycle CDB bypass), CDB capture, release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_rdy_j <= '0;
      r_rdy_k <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        r_qj[i] <= '0;
        r_qk[i] <= '0;
        r_vj[i] <= '0;
        r_vk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        if (w_flush) begin
          r_busy[i] <= 1'b0;
        end else if (w_issue_fire && (w_free_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_qj[i]   <= bus.issue_qj;
          r_qk[i]   <= bus.issue_qk;
          if (bus.issue_qj == '0) begin
            r_rdy_j[i] <= 1'b1;
            r_vj[i]    <= bus.issue_vj;
          end else if (bus.cdb_valid && (bus.cdb_tag == bus.issue_qj)) begin
            r_rdy_j[i] <= 1'b1;
            r_vj[i]    <= bus.cdb_data;
          end else begin
            r_rdy_j[i] <= 1'b0;
          end
          if (bus.issue_qk == '0) begin
            r_rdy_k[i] <= 1'b1;
            r_vk[i]    <= bus.issue_vk;
          end else if (bus.cdb_valid && (bus.cdb_tag == bus.issue_qk)) begin
            r_rdy_k[i] <= 1'b1;
            r_vk[i]    <= bus.cdb_data;
          end else begin
            r_rdy_k[i] <= 1'b0;
          end
        end else if (r_busy[i]) begin
          if (w_handoff && (r_sel == IDX_W'(i))) r_busy[i] <= 1'b0;
          if (!r_rdy_j[i] && bus.cdb_valid && (bus.cdb_tag == r_qj[i])) begin
            r_rdy_j[i] <= 1'b1;
            r_vj[i]    <= bus.cdb_data;
          end
          if (!r_rdy_k[i] && bus.cdb_valid && (bus.cdb_tag == r_qk[i])) begin
            r_rdy_k[i] <= 1'b1;
            r_vk[i]    <= bus.cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_dispatch) begin
        r_mul_a <= r_vj[w_disp_idx];
        r_mul_b <= r_vk[w_disp_idx];
        r_sel   <= w_disp_idx;
        r_cnt   <= CNT_W'(LAT - 1);
      end
      if (w_flush) begin
        r_cnt <= '0;
      end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.mul_res;
        r_out_tag   <= TAG_W'(TAG_BASE) + TAG_W'(r_sel);
      end
      if (w_handoff || w_flush) r_out_valid <= 1'b0;
    end
  end

  assign bus.issue_ready = w_any_free;
  assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_tag     = r_out_tag;
  assign bus.out_data    = r_out_data;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_fmul_rs_sched.sv
// Self-checking bench for fmul_rs_sched: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_fmul_rs_sched;

  localparam int NUM_ENT  = 3;
  localparam int TAG_W    = 4;
  localparam int TAG_BASE = 4;
  localparam int LAT      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef FMUL_RS_FLUSH_EN
  logic flush = 1'b0;
`endif

  fmul_rs_sched_if #(.TAG_W(TAG_W), .NUM_ENT(NUM_ENT)) bif ();

  fmul_rs_sched #(
    .NUM_ENT(NUM_ENT), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE), .LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
`ifdef FMUL_RS_FLUSH_EN
    , .flush(flush)
`endif
  );

  // Stand-in fpMult: truncating single-precision multiply, denormals flushed.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb, m;
    logic [47:0] p;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    ma = a[22:0];  mb = b[22:0];
    if (ea == 8'hFF && ma != 0) return a | 32'h0040_0000;
    if (eb == 8'hFF && mb != 0) return b | 32'h0040_0000;
    if ((ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0)) return 32'h7FC0_0000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p = 48'({1'b1, ma}) * 48'({1'b1, mb});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  assign bif.mul_res = fmul(bif.mul_a, bif.mul_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.issue_valid = 1'b0;
    bif.issue_qj    = '0;
    bif.issue_qk    = '0;
    bif.issue_vj    = '0;
    bif.issue_vk    = '0;
    bif.cdb_valid   = 1'b0;
    bif.cdb_tag     = '0;
    bif.cdb_data    = '0;
    bif.out_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bif.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("out_valid_arrives", 32'(bif.out_valid), 32'd1);
  endtask

  task automatic issue(input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk);
    bif.issue_valid = 1'b1;
    bif.issue_qj = qj; bif.issue_vj = vj;
    bif.issue_qk = qk; bif.issue_vk = vk;
    tick();
    bif.issue_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    string       name;
  } vec_t;
  vec_t vt[7];

  // transaction-level model state for the random run
  logic        m_busy [NUM_ENT];
  logic        m_rj   [NUM_ENT];
  logic        m_rk   [NUM_ENT];
  logic [3:0]  m_qj   [NUM_ENT];
  logic [3:0]  m_qk   [NUM_ENT];
  logic [31:0] m_vj   [NUM_ENT];
  logic [31:0] m_vk   [NUM_ENT];
  logic        m_inflight, m_res_valid;
  int          m_sel, m_disp_edge, edge_no;
  logic [31:0] m_a, m_b, m_res;

  function automatic logic [3:0] rand_q();
    if ($urandom_range(2) == 0) return 4'd0;
    return 4'(4 + $urandom_range(3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ENT; i++) begin
      m_busy[i] = 0; m_rj[i] = 0; m_rk[i] = 0;
      m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
    end
    m_inflight = 0; m_res_valid = 0; m_sel = 0; m_disp_edge = 0;
    m_a = 0; m_b = 0; m_res = 0; edge_no = 0;
  endtask

  // Advance the model across the next clock edge using the inputs now driven.
  task automatic model_step();
    int free_i = -1;
    int rdy_i  = -1;
    int rel_i  = -1;
    edge_no++;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!m_busy[i]) free_i = i;
      if (m_busy[i] && m_rj[i] && m_rk[i] && !(m_inflight && m_sel == i)) rdy_i = i;
    end
    if (m_res_valid) begin
      if (bif.out_ready) begin
        rel_i = m_sel;
        m_res_valid = 0;
        m_inflight = 0;
      end
    end else if (m_inflight) begin
      if (edge_no == m_disp_edge + LAT) begin
        m_res_valid = 1;
        m_res = fmul(m_a, m_b);
      end
    end else if (rdy_i >= 0) begin
      m_inflight = 1;
      m_sel = rdy_i;
      m_disp_edge = edge_no;
      m_a = m_vj[rdy_i];
      m_b = m_vk[rdy_i];
    end
    for (int i = 0; i < NUM_ENT; i++) begin
      if (m_busy[i] && bif.cdb_valid) begin
        if (!m_rj[i] && m_qj[i] == bif.cdb_tag) begin m_rj[i] = 1; m_vj[i] = bif.cdb_data; end
        if (!m_rk[i] && m_qk[i] == bif.cdb_tag) begin m_rk[i] = 1; m_vk[i] = bif.cdb_data; end
      end
    end
    if (bif.issue_valid && free_i >= 0) begin
      m_busy[free_i] = 1;
      m_qj[free_i] = bif.issue_qj;
      m_qk[free_i] = bif.issue_qk;
      m_rj[free_i] = (bif.issue_qj == 0) || (bif.cdb_valid && bif.cdb_tag == bif.issue_qj);
      m_rk[free_i] = (bif.issue_qk == 0) || (bif.cdb_valid && bif.cdb_tag == bif.issue_qk);
      m_vj[free_i] = (bif.issue_qj == 0) ? bif.issue_vj : bif.cdb_data;
      m_vk[free_i] = (bif.issue_qk == 0) ? bif.issue_vk : bif.cdb_data;
    end
    if (rel_i >= 0) m_busy[rel_i] = 0;
  endtask

  task automatic model_compare();
    logic [NUM_ENT-1:0] eb;
    int lf = -1;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      eb[i] = m_busy[i];
      if (!m_busy[i]) lf = i;
    end
    chk("rnd_busy", 32'(bif.busy), 32'(eb));
    chk("rnd_issue_ready", 32'(bif.issue_ready), 32'(lf >= 0));
    if (lf >= 0) chk("rnd_issue_tag", 32'(bif.issue_tag), 32'(TAG_BASE + lf));
    chk("rnd_out_valid", 32'(bif.out_valid), 32'(m_res_valid));
    if (m_res_valid) begin
      chk("rnd_out_tag", 32'(bif.out_tag), 32'(TAG_BASE + m_sel));
      chk("rnd_out_data", bif.out_data, m_res);
    end
    chk("rnd_mul_a", bif.mul_a, m_a);
    chk("rnd_mul_b", bif.mul_b, m_b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] held;

    vt[0] = '{32'h411C_0000, 32'h3F10_0000, 32'h40AF_8000, "mul_9p75_0p5625"};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, "mul_nan_zero"};
    vt[2] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "mul_inf_zero"};
    vt[3] = '{32'hBE80_0000, 32'h4080_0000, 32'hBF80_0000, "mul_neg_quarter_4"};
    vt[4] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "mul_2_3"};
    vt[5] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "mul_neginf_2"};
    vt[6] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "mul_negzero_1"};

    do_reset();
    chk("rst_busy",      32'(bif.busy), 32'd0);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_out_tag",   32'(bif.out_tag), 32'd0);
    chk("rst_out_data",  bif.out_data, 32'd0);
    chk("rst_mul_a",     bif.mul_a, 32'd0);
    chk("rst_mul_b",     bif.mul_b, 32'd0);
    chk("rst_issue_rdy", 32'(bif.issue_ready), 32'd1);
    chk("rst_issue_tag", 32'(bif.issue_tag), 32'(TAG_BASE));

    // vector table: ready operands, one result per entry, latency LAT+1 from issue
    for (int v = 0; v < 7; v++) begin
      bif.out_ready = 1'b1;
      chk({vt[v].name, "_issue_tag"}, 32'(bif.issue_tag), 32'(TAG_BASE));
      issue(4'd0, vt[v].a, 4'd0, vt[v].b);
      chk({vt[v].name, "_busy"}, 32'(bif.busy), 32'd1);
      wait_out(n);
      chk({vt[v].name, "_latency"}, 32'(n), 32'(LAT + 1));
      chk({vt[v].name, "_data"}, bif.out_data, vt[v].p);
      chk({vt[v].name, "_tag"}, 32'(bif.out_tag), 32'(TAG_BASE));
      tick();
      chk({vt[v].name, "_released"}, 32'(bif.out_valid), 32'd0);
      chk({vt[v].name, "_busy_free"}, 32'(bif.busy), 32'd0);
    end

    // pending operand satisfied by the CDB, dispatch one edge after capture
    do_reset();
    bif.out_ready = 1'b1;
    issue(4'd6, 32'h0, 4'd0, 32'hBE80_0000);
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      chk("pend_no_early_dispatch", bif.mul_b, 32'd0);
    end
    bif.cdb_valid = 1'b1; bif.cdb_tag = 4'd6; bif.cdb_data = 32'h4080_0000;
    tick();
    bif.cdb_valid = 1'b0;
    chk("pend_no_dispatch_at_capture", bif.mul_b, 32'd0);
    tick();
    chk("pend_dispatch_a", bif.mul_a, 32'h4080_0000);
    chk("pend_dispatch_b", bif.mul_b, 32'hBE80_0000);
    wait_out(n);
    chk("pend_latency", 32'(n), 32'(LAT));
    chk("pend_data", bif.out_data, 32'hBF80_0000);
    tick();
    chk("pend_busy_free", 32'(bif.busy), 32'd0);

    // same-cycle CDB bypass at issue
    do_reset();
    bif.out_ready = 1'b1;
    bif.cdb_valid = 1'b1; bif.cdb_tag = 4'd5; bif.cdb_data = 32'h3F80_0000;
    issue(4'd0, 32'h4040_0000, 4'd5, 32'hDEAD_BEEF);
    bif.cdb_valid = 1'b0;
    tick();
    chk("byp_dispatch_a", bif.mul_a, 32'h4040_0000);
    chk("byp_dispatch_b", bif.mul_b, 32'h3F80_0000);
    wait_out(n);
    chk("byp_latency", 32'(n), 32'(LAT));
    chk("byp_data", bif.out_data, 32'h4040_0000);
    tick();

    // full station with backpressure, then in-order drain
    do_reset();
    for (int v = 0; v < 3; v++) begin
      chk("full_issue_tag", 32'(bif.issue_tag), 32'(TAG_BASE + v));
      issue(4'd0, vt[v].a, 4'd0, vt[v].b);
    end
    chk("full_issue_ready", 32'(bif.issue_ready), 32'd0);
    chk("full_busy", 32'(bif.busy), 32'd7);
    issue(4'd0, 32'h4000_0000, 4'd0, 32'h4000_0000);
    chk("full_4th_ignored", 32'(bif.busy), 32'd7);
    wait_out(n);
    held = bif.out_data;
    chk("full_first_data", held, vt[0].p);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("full_hold_valid", 32'(bif.out_valid), 32'd1);
      chk("full_hold_data", bif.out_data, held);
      chk("full_hold_tag", 32'(bif.out_tag), 32'(TAG_BASE));
    end
    bif.out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_out(n);
      chk("drain_tag", 32'(bif.out_tag), 32'(TAG_BASE + r));
      chk("drain_data", bif.out_data, vt[r].p);
      tick();
      chk("drain_valid_low", 32'(bif.out_valid), 32'd0);
    end
    chk("drain_busy_free", 32'(bif.busy), 32'd0);
    for (int k = 0; k < LAT + 4; k++) tick();
    chk("drain_no_ghost", 32'(bif.out_valid), 32'd0);

    // asynchronous reset during EXEC
    do_reset();
    issue(4'd0, vt[0].a, 4'd0, vt[0].b);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bif.busy), 32'd0);
    chk("arst_mul_a", bif.mul_a, 32'd0);
    chk("arst_out_valid", 32'(bif.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) tick();
    chk("arst_result_lost", 32'(bif.out_valid), 32'd0);

`ifdef FMUL_RS_FLUSH_EN
    do_reset();
    issue(4'd0, vt[0].a, 4'd0, vt[0].b);
    issue(4'd0, vt[1].a, 4'd0, vt[1].b);
    wait_out(n);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(bif.out_valid), 32'd0);
    chk("flush_busy", 32'(bif.busy), 32'd0);
    chk("flush_mul_a_kept", bif.mul_a, vt[0].a);
`endif

    // randomized run against the transaction-level model
    do_reset();
    model_reset();
    for (int t = 0; t < 800; t++) begin
      bif.issue_valid = 1'($urandom_range(1));
      bif.issue_qj    = rand_q();
      bif.issue_qk    = rand_q();
      bif.issue_vj    = $urandom;
      bif.issue_vk    = $urandom;
      bif.cdb_valid   = ($urandom_range(4) < 2);
      bif.cdb_tag     = 4'($urandom_range(7));
      bif.cdb_data    = $urandom;
      bif.out_ready   = ($urandom_range(2) != 0);
      model_step();
      tick();
      model_compare();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
